// File: rtl/hdmi_tmds_serializer_pkg.sv
// Shared TMDS constants: symbol width, the four control symbols and the
// clock-lane pattern used by the HDMI/DVI output path.
package hdmi_pkg;

    localparam int TMDS_SYMBOL_W = 10;

    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_11 = 10'b1010101011;

    // Five ones then five zeros: one TMDS clock period per symbol time.
    localparam logic [TMDS_SYMBOL_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

endpackage

// File: rtl/hdmi_tmds_serializer_lane_shifter.sv
// One TMDS lane: loads a (possibly inverted) symbol and shifts it out
// BITS_PER_CLK bits per cycle, earliest bit in the LSB of the slice.
module tmds_lane_shifter
    import hdmi_pkg::*;
#(
    parameter int SYMBOL_W     = TMDS_SYMBOL_W,
    parameter int BITS_PER_CLK = 2,
    parameter bit INVERT       = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [SYMBOL_W-1:0]     i_symbol,
    output logic [BITS_PER_CLK-1:0] o_bits
);

    logic [SYMBOL_W-1:0] r_shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_symbol ^ {SYMBOL_W{INVERT}};
        end else begin
            r_shift <= r_shift >> BITS_PER_CLK;
        end
    end

    assign o_bits = r_shift[BITS_PER_CLK-1:0];

endmodule

// File: rtl/hdmi_tmds_serializer.sv
// HDMI/DVI output serializer: accepts one TMDS symbol per lane per symbol time,
// emits BITS_PER_CLK bits per lane per clock plus a generated TMDS clock lane.
module hdmi_tmds_serializer
    import hdmi_pkg::*;
#(
    parameter int                    NUM_LANES    = 3,
    parameter int                    SYMBOL_W     = TMDS_SYMBOL_W,
    parameter int                    BITS_PER_CLK = 2,
    parameter logic [SYMBOL_W-1:0]   CLK_PATTERN  = TMDS_CLK_PATTERN,
    parameter logic [SYMBOL_W-1:0]   IDLE_SYMBOL  = CTRL_00,
    parameter logic [NUM_LANES:0]    INVERT_MASK  = '0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_LANES*SYMBOL_W-1:0]         in_symbols,
    output logic [(NUM_LANES+1)*BITS_PER_CLK-1:0] out_twice,
    output logic                                  symbol_strobe,
    output logic                                  underflow,
    input  logic                                  clear_underflow
);

    localparam int PHASES = SYMBOL_W / BITS_PER_CLK;
    localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

    if (!(BITS_PER_CLK == 1 || BITS_PER_CLK == 2 || BITS_PER_CLK == 5) ||
        (SYMBOL_W % BITS_PER_CLK) != 0) begin : g_bad_bits_per_clk
        $error("hdmi_tmds_serializer: illegal BITS_PER_CLK=%0d", BITS_PER_CLK);
    end

    logic [PW-1:0] r_phase;
    logic          r_strobe;
    logic          r_underflow;
    logic          r_primed;
    logic          w_wrap;
    logic          w_underflow_set;

    assign w_wrap          = (r_phase == LAST_PHASE);
    assign w_underflow_set = w_wrap & ~in_valid & r_primed;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase     <= LAST_PHASE;
            r_strobe    <= 1'b0;
            r_underflow <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_phase  <= w_wrap ? '0 : r_phase + PW'(1);
            r_strobe <= w_wrap;
            if (w_wrap) begin
                r_primed <= 1'b1;
            end
            // A fresh underflow outranks a simultaneous clear request.
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end else if (clear_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign in_ready      = w_wrap;
    assign symbol_strobe = r_strobe;
    assign underflow     = r_underflow;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_data_lane
        logic [SYMBOL_W-1:0] w_symbol;
        assign w_symbol = in_valid ? in_symbols[i*SYMBOL_W +: SYMBOL_W] : IDLE_SYMBOL;

        tmds_lane_shifter #(
            .SYMBOL_W     (SYMBOL_W),
            .BITS_PER_CLK (BITS_PER_CLK),
            .INVERT       (INVERT_MASK[i])
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .i_load   (w_wrap),
            .i_symbol (w_symbol),
            .o_bits   (out_twice[i*BITS_PER_CLK +: BITS_PER_CLK])
        );
    end

    tmds_lane_shifter #(
        .SYMBOL_W     (SYMBOL_W),
        .BITS_PER_CLK (BITS_PER_CLK),
        .INVERT       (INVERT_MASK[NUM_LANES])
    ) u_clock_lane (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_wrap),
        .i_symbol (CLK_PATTERN),
        .o_bits   (out_twice[NUM_LANES*BITS_PER_CLK +: BITS_PER_CLK])
    );

endmodule

// File: tb/tb_hdmi_tmds_serializer.sv
// Directed bench for hdmi_tmds_serializer: default, inverted-lane and
// 5-bits-per-clock instances driven from one linear stimulus sequence.
module tb_hdmi_tmds_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [29:0] in_symbols;
    logic        clr;

    logic        d_ready, d_strb, d_uf;
    logic [7:0]  d_out;
    logic        i_ready, i_strb, i_uf;
    logic [7:0]  i_out;

    logic        b_valid;
    logic [9:0]  b_sym;
    logic        b_ready, b_strb, b_uf;
    logic [9:0]  b_out;

    int checks   = 0;
    int failures = 0;

    hdmi_tmds_serializer u_def (
        .clock           (clk),
        .reset           (rst),
        .in_valid        (in_valid),
        .in_ready        (d_ready),
        .in_symbols      (in_symbols),
        .out_twice       (d_out),
        .symbol_strobe   (d_strb),
        .underflow       (d_uf),
        .clear_underflow (clr)
    );

    hdmi_tmds_serializer #(.INVERT_MASK(4'b1001)) u_inv (
        .clock           (clk),
        .reset           (rst),
        .in_valid        (in_valid),
        .in_ready        (i_ready),
        .in_symbols      (in_symbols),
        .out_twice       (i_out),
        .symbol_strobe   (i_strb),
        .underflow       (i_uf),
        .clear_underflow (clr)
    );

    hdmi_tmds_serializer #(.NUM_LANES(1), .BITS_PER_CLK(5)) u_b5 (
        .clock           (clk),
        .reset           (rst),
        .in_valid        (b_valid),
        .in_ready        (b_ready),
        .in_symbols      (b_sym),
        .out_twice       (b_out),
        .symbol_strobe   (b_strb),
        .underflow       (b_uf),
        .clear_underflow (1'b0)
    );

    // Hand-computed slice sequences, packed {s4,s3,s2,s1,s0} with s0 first in time.
    localparam logic [9:0] E_CLK     = {2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
    localparam logic [9:0] E_CLK_INV = {2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    localparam logic [9:0] E_IDLE    = {2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
    localparam logic [9:0] E_2AA     = {2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    localparam logic [9:0] E_ONES    = {2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    localparam logic [9:0] E_ZERO    = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in a wrap window; presents one symbol set, then checks the 5 cycles it occupies.
    task automatic play(input string tag, input bit inv, input bit v, input logic [29:0] syms,
                        input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                        input logic [9:0] ec, input logic [4:0] e_uf,
                        input int clr_k, input bit clr_wrap);
        logic [7:0] o;
        in_valid   = v;
        in_symbols = syms;
        clr        = clr_wrap;
        chk({tag, "_ready_wrap"}, 32'(inv ? i_ready : d_ready), 32'd1);
        step();
        in_valid   = 1'b1;
        in_symbols = 30'h25A5A5A5;
        clr        = 1'b0;
        for (int k = 0; k < 5; k++) begin
            o = inv ? i_out : d_out;
            chk({tag, "_lane0"}, 32'(o[1:0]), 32'(e0[2*k +: 2]));
            chk({tag, "_lane1"}, 32'(o[3:2]), 32'(e1[2*k +: 2]));
            chk({tag, "_lane2"}, 32'(o[5:4]), 32'(e2[2*k +: 2]));
            chk({tag, "_clk"},   32'(o[7:6]), 32'(ec[2*k +: 2]));
            chk({tag, "_strobe"}, 32'(inv ? i_strb : d_strb), 32'(k == 0));
            chk({tag, "_ready"},  32'(inv ? i_ready : d_ready), 32'(k == 4));
            if (!inv) chk({tag, "_underflow"}, 32'(d_uf), 32'(e_uf[k]));
            clr = (k == clr_k);
            if (k < 4) step();
        end
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_symbols = '0;
        clr        = 1'b0;
        b_valid    = 1'b0;
        b_sym      = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_ready",     32'(d_ready), 32'd1);
        chk("rst_out",       32'(d_out),   32'd0);
        chk("rst_strobe",    32'(d_strb),  32'd0);
        chk("rst_underflow", 32'(d_uf),    32'd0);

        play("first", 0, 1, {3{10'h2AA}}, E_2AA, E_2AA, E_2AA, E_CLK, 5'b00000, -1, 0);

        for (int r = 0; r < 2; r++) begin
            play("alt_hi", 0, 1, {10'h000, 10'h000, 10'h3FF}, E_ONES, E_ZERO, E_ZERO, E_CLK, 5'b00000, -1, 0);
            play("alt_lo", 0, 1, {10'h000, 10'h000, 10'h000}, E_ZERO, E_ZERO, E_ZERO, E_CLK, 5'b00000, -1, 0);
        end

        play("uf_set",  0, 0, 30'h0, E_IDLE, E_IDLE, E_IDLE, E_CLK, 5'b11111, -1, 0);
        play("uf_clr",  0, 1, {3{10'h2AA}}, E_2AA, E_2AA, E_2AA, E_CLK, 5'b00011, 1, 0);
        play("uf_both", 0, 0, 30'h0, E_IDLE, E_IDLE, E_IDLE, E_CLK, 5'b11111, -1, 1);

        // Abort a symbol at phase 2 with reset.
        in_valid   = 1'b1;
        in_symbols = {3{10'h3FF}};
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_lane0_busy", 32'(d_out[1:0]), 32'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_out",       32'(d_out), 32'd0);
        chk("mid_rst_strobe",    32'(d_strb), 32'd0);
        chk("mid_rst_underflow", 32'(d_uf), 32'd0);
        rst = 1'b0;
        chk("mid_rel_ready", 32'(d_ready), 32'd1);
        play("post_rst_first",  0, 0, 30'h0, E_IDLE, E_IDLE, E_IDLE, E_CLK, 5'b00000, -1, 0);
        play("post_rst_second", 0, 0, 30'h0, E_IDLE, E_IDLE, E_IDLE, E_CLK, 5'b11111, -1, 0);

        play("inv", 1, 1, 30'h0, E_ONES, E_ZERO, E_ZERO, E_CLK_INV, 5'b00000, -1, 0);

        // Five bits per clock, single data lane.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b5_rst_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_sym   = 10'h01F;
        step();
        b_sym = 10'h3E0;
        chk("b5_s0_lane0",  32'(b_out[4:0]), 32'h1F);
        chk("b5_s0_clk",    32'(b_out[9:5]), 32'h1F);
        chk("b5_s0_strobe", 32'(b_strb),     32'd1);
        chk("b5_s0_ready",  32'(b_ready),    32'd0);
        step();
        chk("b5_s1_lane0",  32'(b_out[4:0]), 32'h00);
        chk("b5_s1_clk",    32'(b_out[9:5]), 32'h00);
        chk("b5_s1_strobe", 32'(b_strb),     32'd0);
        chk("b5_s1_ready",  32'(b_ready),    32'd1);
        step();
        b_valid = 1'b0;
        chk("b5_t0_lane0", 32'(b_out[4:0]), 32'h00);
        chk("b5_t0_ready", 32'(b_ready),    32'd0);
        step();
        chk("b5_t1_lane0", 32'(b_out[4:0]), 32'h1F);
        chk("b5_t1_ready", 32'(b_ready),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
